// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage register pipe with per-stage valid bits, stall, flush and an occupancy count.
// Define DFF_PIPE_ZERO_INVALID_EN to force every invalid stage to carry RST_VAL.
module dff_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  input  logic                       wen,
  input  logic                       flush,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] d_in;
  logic [CW-1:0]    count_next;

  always_comb begin
`ifdef DFF_PIPE_ZERO_INVALID_EN
    d_in = d_valid ? d : RST_VAL;
`else
    d_in = d;
`endif
  end

  // Modular add/subtract is exact: the true result always lies in 0..DEPTH.
  assign count_next = count + CW'(d_valid) - CW'(valid[DEPTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= RST_VAL;
      valid <= '0;
      count <= '0;
    end else if (flush) begin
      valid <= '0;
      count <= '0;
`ifdef DFF_PIPE_ZERO_INVALID_EN
      for (int i = 0; i < DEPTH; i++) data[i] <= RST_VAL;
`endif
    end else if (wen) begin
      data[0]  <= d_in;
      valid[0] <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data[i]  <= data[i-1];
        valid[i] <= valid[i-1];
      end
      count <= count_next;
    end
  end

  assign q       = data[DEPTH-1];
  assign q_valid = valid[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed bench for dff_pipe, DEPTH=3 and DEPTH=1 instances sharing one stimulus,
// checked every cycle against a sliding-window history model plus literal expectations.
module tb_dff_pipe;

`ifdef DFF_PIPE_ZERO_INVALID_EN
  localparam bit ZERO_INV = 1'b1;
`else
  localparam bit ZERO_INV = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] d;
  logic        d_valid;
  logic        wen;
  logic        flush;
  logic [15:0] q3, q1;
  logic        qv3, qv1;
  logic [1:0]  count3;
  logic [0:0]  count1;

  int checks   = 0;
  int failures = 0;
  bit mdl_ok   = 1'b0;

  // History of advances since reset, newest at the back; the last DEPTH entries are what a DEPTH pipe holds.
  logic [15:0] hd[$];
  bit          hv[$];

  dff_pipe #(.WIDTH(16), .DEPTH(3), .RST_VAL(16'h0000)) dut3 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .wen(wen), .flush(flush),
    .q(q3), .q_valid(qv3), .count(count3)
  );

  dff_pipe #(.WIDTH(16), .DEPTH(1), .RST_VAL(16'h0000)) dut1 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .wen(wen), .flush(flush),
    .q(q1), .q_valid(qv1), .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      hd.delete();
      hv.delete();
      for (int i = 0; i < 8; i++) begin
        hd.push_back(16'h0000);
        hv.push_back(1'b0);
      end
      mdl_ok <= 1'b1;
    end else if (flush) begin
      for (int i = 0; i < hv.size(); i++) begin
        hv[i] = 1'b0;
        if (ZERO_INV) hd[i] = 16'h0000;
      end
    end else if (wen) begin
      hd.push_back((ZERO_INV && !d_valid) ? 16'h0000 : d);
      hv.push_back(d_valid);
      void'(hd.pop_front());
      void'(hv.pop_front());
    end
  end

  function automatic logic [15:0] exp_q(input int dep);
    return hd[hd.size() - dep];
  endfunction

  function automatic bit exp_qv(input int dep);
    return hv[hv.size() - dep];
  endfunction

  function automatic int exp_cnt(input int dep);
    int n = 0;
    for (int i = hv.size() - dep; i < hv.size(); i++) n += int'(hv[i]);
    return n;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mdl_ok) begin
      cmp("model3_q_valid", 64'(qv3), 64'(exp_qv(3)));
      cmp("model3_count", 64'(count3), 64'(exp_cnt(3)));
      if (exp_qv(3) || ZERO_INV) cmp("model3_q", 64'(q3), 64'(exp_q(3)));
      cmp("model1_q_valid", 64'(qv1), 64'(exp_qv(1)));
      cmp("model1_count", 64'(count1), 64'(exp_cnt(1)));
      if (exp_qv(1) || ZERO_INV) cmp("model1_q", 64'(q1), 64'(exp_q(1)));
    end
  end

  task automatic applyStimulus(input bit r, input bit f, input bit w, input bit dv, input logic [15:0] dat);
    rst     = r;
    flush   = f;
    wen     = w;
    d_valid = dv;
    d       = dat;
    @(posedge clk);
    @(negedge clk);
  endtask

  // chkq=0 marks q as don't-care unless invalid stages are forced to RST_VAL.
  task automatic checkOutput(input string name, input int dep, input logic [15:0] eq, input bit chkq,
                             input bit eqv, input int ec);
    if (dep == 3) begin
      cmp({name, "_q_valid"}, 64'(qv3), 64'(eqv));
      cmp({name, "_count"}, 64'(count3), 64'(ec));
      if (chkq || eqv || ZERO_INV) cmp({name, "_q"}, 64'(q3), 64'(eq));
    end else begin
      cmp({name, "_q_valid"}, 64'(qv1), 64'(eqv));
      cmp({name, "_count"}, 64'(count1), 64'(ec));
      if (chkq || eqv || ZERO_INV) cmp({name, "_q"}, 64'(q1), 64'(eq));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wen = 1'b0; d_valid = 1'b0; d = 16'h0000;
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    applyStimulus(1, 0, 1, 1, 16'hDEAD);
    checkOutput("reset_p3", 3, 16'h0000, 1, 0, 0);
    checkOutput("reset_p1", 1, 16'h0000, 1, 0, 0);

    // Single-stage pipe: first entry visible after one edge, a second keeps count at 1.
    applyStimulus(0, 0, 1, 1, 16'h0F0F);
    checkOutput("d1_first_p1", 1, 16'h0F0F, 1, 1, 1);
    checkOutput("d1_first_p3", 3, 16'h0000, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 16'h1234);
    checkOutput("d1_second_p1", 1, 16'h1234, 1, 1, 1);
    checkOutput("d1_second_p3", 3, 16'h0000, 0, 0, 2);

    // Fill from reset.
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkOutput("reset2_p3", 3, 16'h0000, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 16'h1111);
    applyStimulus(0, 0, 1, 1, 16'h2222);
    checkOutput("fill2_p3", 3, 16'h0000, 0, 0, 2);
    applyStimulus(0, 0, 1, 1, 16'h3333);
    checkOutput("fill3_p3", 3, 16'h1111, 1, 1, 3);
    checkOutput("fill3_p1", 1, 16'h3333, 1, 1, 1);

    // Stall while d and d_valid toggle.
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, k[0], 16'h5A5A ^ 16'(k));
    checkOutput("stall_p3", 3, 16'h1111, 1, 1, 3);
    checkOutput("stall_p1", 1, 16'h3333, 1, 1, 1);

    // Full pipe advance drops the oldest entry.
    applyStimulus(0, 0, 1, 1, 16'h4444);
    checkOutput("full_adv_p3", 3, 16'h2222, 1, 1, 3);
    checkOutput("full_adv_p1", 1, 16'h4444, 1, 1, 1);

    // Bubble between two valid entries, then drain.
    applyStimulus(1, 0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 1, 1, 16'hAAAA);
    checkOutput("bub_a_p3", 3, 16'h0000, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 16'hCCCC);
    checkOutput("bub_gap_p3", 3, 16'h0000, 0, 0, 1);
    checkOutput("bub_gap_p1", 1, 16'h0000, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 16'hBBBB);
    checkOutput("bub_b_p3", 3, 16'hAAAA, 1, 1, 2);
    checkOutput("bub_b_p1", 1, 16'hBBBB, 1, 1, 1);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkOutput("drain1_p3", 3, 16'h0000, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkOutput("drain2_p3", 3, 16'hBBBB, 1, 1, 1);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkOutput("drain3_p3", 3, 16'h0000, 0, 0, 0);
    checkOutput("drain3_p1", 1, 16'h0000, 0, 0, 0);

    // Flush with wen and d_valid on a full pipe.
    applyStimulus(0, 0, 1, 1, 16'h1111);
    applyStimulus(0, 0, 1, 1, 16'h2222);
    applyStimulus(0, 0, 1, 1, 16'h3333);
    checkOutput("refill_p3", 3, 16'h1111, 1, 1, 3);
    applyStimulus(0, 1, 1, 1, 16'h9999);
    checkOutput("flush_p3", 3, ZERO_INV ? 16'h0000 : 16'h1111, 1, 0, 0);
    checkOutput("flush_p1", 1, ZERO_INV ? 16'h0000 : 16'h3333, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'h9999);
    checkOutput("post_flush_p3", 3, ZERO_INV ? 16'h0000 : 16'h1111, 1, 0, 0);

    // Reset together with flush and wen mid-stream, then a fresh entry.
    applyStimulus(0, 0, 1, 1, 16'h6666);
    applyStimulus(0, 0, 1, 1, 16'h7777);
    checkOutput("mid_p3", 3, 16'h0000, 0, 0, 2);
    applyStimulus(1, 1, 1, 1, 16'h8888);
    checkOutput("rst_flush_p3", 3, 16'h0000, 1, 0, 0);
    checkOutput("rst_flush_p1", 1, 16'h0000, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 16'h5555);
    checkOutput("post_rst1_p3", 3, 16'h0000, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkOutput("post_rst2_p3", 3, 16'h0000, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkOutput("post_rst3_p3", 3, 16'h5555, 1, 1, 1);

    // Flush while stalled still clears everything.
    applyStimulus(0, 1, 0, 1, 16'h1234);
    checkOutput("flush_stall_p3", 3, 16'h0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 3: number of register stages; legal range 1..8.
REQ-003 Parameter RST_VAL, default 0: WIDTH-bit value loaded into every data stage on reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 d  input  WIDTH  data entering stage 0.
REQ-007 d_valid  input  1  marks d as a valid entry.
REQ-008 wen  input  1  advance enable; high shifts the pipe one stage, low stalls every stage.
REQ-009 flush  input  1  invalidates all stages and the incoming entry.
REQ-010 q  output  WIDTH  data of the last stage (stage DEPTH-1).
REQ-011 q_valid  output  1  valid bit of the last stage.
REQ-012 count  output  $clog2(DEPTH+1)  number of valid entries currently held.

Function
REQ-013 Each stage i holds data[i] and valid[i]; q and q_valid are driven directly from stage DEPTH-1, with no combinational path from any input.
REQ-014 Priority order per edge: rst, then flush, then wen, then hold.
REQ-015 wen=1, flush=0: stage 0 loads {d, d_valid}; stage i loads stage i-1 for i=1..DEPTH-1; stage DEPTH-1 contents are discarded.
REQ-016 wen=0, flush=0: all data and valid bits hold; d and d_valid are ignored.
REQ-017 Latency: an entry presented with wen=1 at edge N appears on q at edge N+DEPTH-1 if wen=1 on every intervening edge; each wen=0 edge adds one cycle.
REQ-018 flush=1: every valid bit clears to 0 regardless of wen; the incoming d_valid is discarded; data handling is set by REQ-026/027.
REQ-019 count update, wen=1, flush=0: count_next = count + d_valid - valid[DEPTH-1], evaluated as one saturating-free operation (the result always lies in 0..DEPTH).
REQ-020 count holds when wen=0, and becomes 0 on flush or rst.
REQ-021 count always equals the population count of valid[]; the verification bench checks this invariant every cycle.
REQ-022 DEPTH=1: stage 0 is the output stage; d_valid=1 with valid[0]=1 and wen=1 leaves count unchanged.
REQ-023 Full pipe (count=DEPTH) with wen=1 and d_valid=1: the oldest entry is dropped, count stays DEPTH; no stall is generated internally.

Reset
REQ-024 On rst=1 at a rising edge: all valid bits 0, all data stages RST_VAL, count 0; q=RST_VAL, q_valid=0 from the next cycle.
REQ-025 rst asserted mid-operation, including together with flush or wen, discards all in-flight entries; the first post-reset entry is taken on the first edge with rst=0 and wen=1.

Configuration
REQ-026 Macro DFF_PIPE_ZERO_INVALID_EN defined: on flush, every data stage loads RST_VAL; on any advance, stage 0 loads RST_VAL instead of d when d_valid=0, so an invalid stage always shows RST_VAL on q.
REQ-027 Macro not defined: flush clears valid bits only, and data stages hold; on advance, stage 0 loads d regardless of d_valid, and q of an invalid stage is don't-care.

Verification (WIDTH=16, DEPTH=3, RST_VAL=0)
REQ-028 Reset then wen=1 with d=0x1111/0x2222/0x3333 (d_valid=1) on 3 edges -> q=0x1111 and q_valid=1 after edge 3, count=3.
REQ-029 Full pipe, wen=0 for 4 cycles while d toggles -> q, q_valid and count unchanged; resume wen=1 with d=0x4444 -> q=0x2222, count=3.
REQ-030 Entries 0xAAAA (valid), bubble (d_valid=0), 0xBBBB (valid) -> q_valid sequence 1,0,1 at the output, with count tracking 1,1,2 then falling as entries leave.
REQ-031 Full pipe, flush=1 together with wen=1 and d_valid=1 -> count=0, q_valid=0 next cycle; q=0x0000 with the macro defined, q holds its prior value without it.
REQ-032 rst=1 asserted together with flush=1 and wen=1 mid-stream -> q=0x0000, q_valid=0, count=0; next entry 0x5555 reaches q 3 edges after rst falls.
REQ-033 DEPTH=1 instance: d=0x0F0F, d_valid=1, wen=1 -> q=0x0F0F and count=1 after 1 edge; a second valid entry keeps count=1.
